// File: rtl/branch_resolve_unit_pkg.sv
// Shared definitions for the branch resolve unit: datapath width, FSM encodings, ALU opcodes.
package branch_resolve_unit_pkg;

    localparam int unsigned XLEN = 64;

    // FSM state encodings
    localparam logic [1:0] ST_RUN    = 2'd0;
    localparam logic [1:0] ST_SQUASH = 2'd1;
    localparam logic [1:0] ST_TRAP   = 2'd2;

    typedef logic [1:0] state_t;

    // ALU opcode that produces the JALR target (base + offset)
    localparam int unsigned ALU_OP_W = 4;
    localparam logic [ALU_OP_W-1:0] ALU_OP_JALR_ADD = 4'b1011;

endpackage

// File: rtl/branch_resolve_unit_if.sv
// EX-stage bundle seen by the branch resolve unit: instruction class, operands and ALU outcome.
interface branch_resolve_unit_if;
    import branch_resolve_unit_pkg::*;

    logic            valid;
    logic            is_branch;
    logic            is_jal;
    logic            is_jalr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] alu_result;
    logic            br_taken_n;

    modport master (
        output valid, is_branch, is_jal, is_jalr, pc, imm, alu_result, br_taken_n
    );

    modport slave (
        input valid, is_branch, is_jal, is_jalr, pc, imm, alu_result, br_taken_n
    );
endinterface

// File: rtl/branch_resolve_unit_br_target_gen.sv
// Combinational redirect target and word-alignment check for branch/JAL/JALR.
module br_target_gen
    import branch_resolve_unit_pkg::*;
(
    input  logic            is_jalr,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] alu_result,
    output logic [XLEN-1:0] target_c,
    output logic            misalign_c
);

    // JALR clears bit 0 of base+offset; others are PC-relative, wrapping modulo 2^64
    always_comb begin
        target_c   = is_jalr ? (alu_result & ~XLEN'(1)) : (pc + imm);
        misalign_c = (target_c[1:0] != 2'b00);
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// Resolves EX-stage control transfers: steers the fetch PC, flushes, links, traps on
// misaligned targets and keeps saturating branch statistics.
module branch_resolve_unit
    import branch_resolve_unit_pkg::*;
#(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter int unsigned CNT_W    = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                stall,
    input  logic                trap_ack,
    branch_resolve_unit_if.slave ex,
    output logic [XLEN-1:0]     if_pc,
    output logic                flush,
    output logic                link_valid,
    output logic [XLEN-1:0]     link_data,
    output logic                trap_misalign,
    output logic [XLEN-1:0]     trap_addr,
    output logic [CNT_W-1:0]    br_cnt,
    output logic [CNT_W-1:0]    taken_cnt
);

    state_t          state_q;
    state_t          state_d;
    logic [XLEN-1:0] pc_d;
    logic [XLEN-1:0] trap_addr_d;

    logic            is_jalr;
    logic            is_jal;
    logic            is_br;
    logic            live;
    logic            redirect;
    logic            misalign;
    logic            br_ev;
    logic            taken_ev;
    logic [XLEN-1:0] target;
    logic            tgt_misalign;

    // Overlapping class bits resolve as jalr > jal > branch
    always_comb begin
        is_jalr  = ex.is_jalr;
        is_jal   = ex.is_jal & ~ex.is_jalr;
        is_br    = ex.is_branch & ~ex.is_jal & ~ex.is_jalr;
        live     = ex.valid & (state_q == ST_RUN);
        redirect = live & (is_jalr | is_jal | (is_br & ~ex.br_taken_n));
        misalign = redirect & tgt_misalign;
        br_ev    = live & is_br;
        taken_ev = br_ev & ~ex.br_taken_n;
    end

    br_target_gen u_target (
        .is_jalr    (is_jalr),
        .pc         (ex.pc),
        .imm        (ex.imm),
        .alu_result (ex.alu_result),
        .target_c   (target),
        .misalign_c (tgt_misalign)
    );

    // Combinational outputs are gated off while reset is held
    always_comb begin
        flush         = rst_n & redirect;
        link_valid    = rst_n & live & (is_jal | is_jalr);
        link_data     = ex.pc + XLEN'(4);
        trap_misalign = (state_q == ST_TRAP);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_RUN;
            if_pc     <= RESET_PC;
            trap_addr <= '0;
        end else begin
            state_q   <= state_d;
            if_pc     <= pc_d;
            trap_addr <= trap_addr_d;
        end
    end

    // Next-state and next-PC selection; a redirect wins over a stall
    always_comb begin
        state_d     = state_q;
        pc_d        = if_pc;
        trap_addr_d = trap_addr;
        case (state_q)
            ST_RUN: begin
                if (redirect) begin
                    if (misalign) begin
                        trap_addr_d = target;
                        state_d     = ST_TRAP;
                    end else begin
                        pc_d    = target;
                        state_d = ST_SQUASH;
                    end
                end else if (!stall) begin
                    pc_d = if_pc + XLEN'(4);
                end
            end
            ST_SQUASH: begin
                if (!stall) begin
                    pc_d = if_pc + XLEN'(4);
                end
                state_d = ST_RUN;
            end
            ST_TRAP: begin
                if (trap_ack) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    // Saturating resolved/taken branch counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            br_cnt    <= '0;
            taken_cnt <= '0;
        end else begin
            if (br_ev && (br_cnt != '1)) begin
                br_cnt <= br_cnt + CNT_W'(1);
            end
            if (taken_ev && (taken_cnt != '1)) begin
                taken_cnt <= taken_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed vector bench for branch_resolve_unit, with narrow counters so saturation is reachable.
module tb_branch_resolve_unit;
    import branch_resolve_unit_pkg::*;

    localparam int unsigned CW = 4;
    localparam logic [63:0] NEG8 = 64'hFFFF_FFFF_FFFF_FFF8;
    localparam logic [63:0] HIPC = 64'hFFFF_FFFF_FFFF_FFF0;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          stall = 1'b0;
    logic          trap_ack = 1'b0;
    logic [63:0]   if_pc;
    logic          flush;
    logic          link_valid;
    logic [63:0]   link_data;
    logic          trap_misalign;
    logic [63:0]   trap_addr;
    logic [CW-1:0] br_cnt;
    logic [CW-1:0] taken_cnt;

    int checks = 0;
    int errors = 0;

    branch_resolve_unit_if exb ();

    branch_resolve_unit #(.RESET_PC(64'h0), .CNT_W(CW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall         (stall),
        .trap_ack      (trap_ack),
        .ex            (exb),
        .if_pc         (if_pc),
        .flush         (flush),
        .link_valid    (link_valid),
        .link_data     (link_data),
        .trap_misalign (trap_misalign),
        .trap_addr     (trap_addr),
        .br_cnt        (br_cnt),
        .taken_cnt     (taken_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        s, v, b, j, jr;
        logic [63:0] pc, imm, alu;
        logic        tn, ack;
        logic        fl, lv;
        logic [63:0] ld;
        logic [63:0] npc;
        logic        tr;
        logic [63:0] ta;
        logic [3:0]  bc, tc;
    } vec_t;

    vec_t vec [18];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic s, input logic v, input logic b, input logic j, input logic jr,
                         input logic [63:0] pc, input logic [63:0] imm, input logic [63:0] alu,
                         input logic tn, input logic ack);
        stall          = s;
        exb.valid      = v;
        exb.is_branch  = b;
        exb.is_jal     = j;
        exb.is_jalr    = jr;
        exb.pc         = pc;
        exb.imm        = imm;
        exb.alu_result = alu;
        exb.br_taken_n = tn;
        trap_ack       = ack;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 64'h0, 1'b1, 1'b0);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        //        s v b j jr pc          imm      alu       tn ack fl lv ld              npc         tr ta      bc tc
        vec[0]  = '{0,0,0,0,0, 64'h0,      64'h0,   64'h0,    1,0, 0,0, 64'h4,        64'h4,      0, 64'h0,  0, 0};
        vec[1]  = '{0,0,0,0,0, 64'h0,      64'h0,   64'h0,    1,0, 0,0, 64'h4,        64'h8,      0, 64'h0,  0, 0};
        vec[2]  = '{0,0,0,0,0, 64'h0,      64'h0,   64'h0,    1,0, 0,0, 64'h4,        64'hC,      0, 64'h0,  0, 0};
        vec[3]  = '{0,1,1,0,0, 64'h100,    64'h40,  64'h0,    0,0, 1,0, 64'h104,      64'h140,    0, 64'h0,  1, 1};
        vec[4]  = '{0,1,0,1,0, 64'h200,    64'h4,   64'h0,    1,0, 0,0, 64'h204,      64'h144,    0, 64'h0,  1, 1};
        vec[5]  = '{1,1,1,0,0, 64'h300,    64'h10,  64'h0,    1,0, 0,0, 64'h304,      64'h144,    0, 64'h0,  2, 1};
        vec[6]  = '{0,1,0,0,1, 64'h80,     64'h0,   64'h2001, 1,0, 1,1, 64'h84,       64'h2000,   0, 64'h0,  2, 1};
        vec[7]  = '{1,0,0,0,0, 64'h0,      64'h0,   64'h0,    1,0, 0,0, 64'h4,        64'h2000,   0, 64'h0,  2, 1};
        vec[8]  = '{1,1,1,0,0, 64'h2000,   NEG8,    64'h0,    0,0, 1,0, 64'h2004,     64'h1FF8,   0, 64'h0,  3, 2};
        vec[9]  = '{0,0,0,0,0, 64'h0,      64'h0,   64'h0,    1,0, 0,0, 64'h4,        64'h1FFC,   0, 64'h0,  3, 2};
        vec[10] = '{0,1,1,1,0, 64'h400,    64'h20,  64'h0,    1,0, 1,1, 64'h404,      64'h420,    0, 64'h0,  3, 2};
        vec[11] = '{0,0,0,0,0, 64'h0,      64'h0,   64'h0,    1,0, 0,0, 64'h4,        64'h424,    0, 64'h0,  3, 2};
        vec[12] = '{0,1,0,1,0, 64'h10,     64'h6,   64'h0,    1,0, 1,1, 64'h14,       64'h424,    1, 64'h16, 3, 2};
        vec[13] = '{0,1,1,0,0, 64'h500,    64'h8,   64'h0,    0,0, 0,0, 64'h504,      64'h424,    1, 64'h16, 3, 2};
        vec[14] = '{0,0,0,0,0, 64'h0,      64'h0,   64'h0,    1,1, 0,0, 64'h4,        64'h424,    0, 64'h16, 3, 2};
        vec[15] = '{0,0,0,0,0, 64'h0,      64'h0,   64'h0,    1,0, 0,0, 64'h4,        64'h428,    0, 64'h16, 3, 2};
        vec[16] = '{0,1,1,0,0, HIPC,       64'h20,  64'h0,    0,0, 1,0, 64'hFFFF_FFFF_FFFF_FFF4, 64'h10, 0, 64'h16, 4, 3};
        vec[17] = '{0,0,0,0,0, 64'h0,      64'h0,   64'h0,    1,0, 0,0, 64'h4,        64'h14,     0, 64'h16, 4, 3};

        idle();
        #12;
        chk("reset if_pc", if_pc, 64'h0);
        chk("reset br_cnt", 64'(br_cnt), 64'h0);
        chk("reset taken_cnt", 64'(taken_cnt), 64'h0);
        chk("reset trap_addr", trap_addr, 64'h0);
        chk("reset trap", 64'(trap_misalign), 64'h0);
        rst_n = 1'b1;

        for (int i = 0; i < 18; i++) begin
            drive(vec[i].s, vec[i].v, vec[i].b, vec[i].j, vec[i].jr,
                  vec[i].pc, vec[i].imm, vec[i].alu, vec[i].tn, vec[i].ack);
            #1;
            chk($sformatf("v%0d flush", i), 64'(flush), 64'(vec[i].fl));
            chk($sformatf("v%0d link_valid", i), 64'(link_valid), 64'(vec[i].lv));
            chk($sformatf("v%0d link_data", i), link_data, vec[i].ld);
            cyc();
            chk($sformatf("v%0d if_pc", i), if_pc, vec[i].npc);
            chk($sformatf("v%0d trap", i), 64'(trap_misalign), 64'(vec[i].tr));
            chk($sformatf("v%0d trap_addr", i), trap_addr, vec[i].ta);
            chk($sformatf("v%0d br_cnt", i), 64'(br_cnt), 64'(vec[i].bc));
            chk($sformatf("v%0d taken_cnt", i), 64'(taken_cnt), 64'(vec[i].tc));
        end

        // br_cnt saturation using stalled not-taken branches
        for (int k = 0; k < 11; k++) begin
            drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 64'h600, 64'h8, 64'h0, 1'b1, 1'b0);
            cyc();
        end
        chk("br_cnt at max", 64'(br_cnt), 64'hF);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 64'h600, 64'h8, 64'h0, 1'b1, 1'b0);
        cyc();
        chk("br_cnt saturated", 64'(br_cnt), 64'hF);
        chk("taken_cnt unchanged", 64'(taken_cnt), 64'h3);
        chk("pc held by stall", if_pc, 64'h14);

        // taken_cnt saturation via taken branch + squash pairs
        for (int k = 0; k < 13; k++) begin
            drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 64'h0, 64'h8, 64'h0, 1'b0, 1'b0);
            cyc();
            idle();
            cyc();
        end
        chk("taken_cnt saturated", 64'(taken_cnt), 64'hF);
        chk("br_cnt still max", 64'(br_cnt), 64'hF);
        chk("pc after squash", if_pc, 64'hC);

        // Reset asserted while in TRAP, with a JAL still presented
        drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 64'h10, 64'h6, 64'h0, 1'b1, 1'b0);
        cyc();
        chk("trap entered", 64'(trap_misalign), 64'h1);
        chk("trap pc held", if_pc, 64'hC);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 64'h40, 64'h10, 64'h0, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("rst trap pc", if_pc, 64'h0);
        chk("rst trap flag", 64'(trap_misalign), 64'h0);
        chk("rst trap_addr", trap_addr, 64'h0);
        chk("rst flush forced", 64'(flush), 64'h0);
        chk("rst br_cnt", 64'(br_cnt), 64'h0);
        drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 64'h40, 64'h10, 64'h0, 1'b1, 1'b0);
        #1;
        chk("rst link_valid forced", 64'(link_valid), 64'h0);
        idle();
        #1;
        rst_n = 1'b1;
        cyc();
        chk("post-rst pc", if_pc, 64'h4);
        chk("post-rst trap", 64'(trap_misalign), 64'h0);

        // Reset asserted while in SQUASH: next redirect is honoured immediately
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 64'h100, 64'h40, 64'h0, 1'b0, 1'b0);
        cyc();
        chk("squash pc", if_pc, 64'h140);
        rst_n = 1'b0;
        #1;
        chk("rst squash pc", if_pc, 64'h0);
        rst_n = 1'b1;
        #1;
        chk("post-rst redirect flush", 64'(flush), 64'h1);
        cyc();
        chk("post-rst redirect pc", if_pc, 64'h140);
        chk("post-rst br_cnt", 64'(br_cnt), 64'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
